ahfp_sub_feeder: RTL and testbench
==================================

Name: ahfp_sub_feeder

Overview:
- Upstream operand-sequencing stage for the combinational single-precision subtractor ahfp_sub; also captures that subtractor's output.
- Accepts a valid/ready stream of IEEE-754 single words.
- Pairs the words into held (dataa, datab) registers that drive the subtractor, waits SUB_LAT cycles, then registers the result as a valid/ready output stream.
- Two pairing modes: pair mode (a,b,a,b...) and delta mode (x[n]-x[n-1]).

Parameters:
- SUB_LAT, 1, cycles from an operand-register update to the result being sampled; legal range 1..15. A later pipelined subtractor needs only this change.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous abort to IDLE; delta history is discarded.
- delta_mode, input, 1, 0 = pair mode, 1 = delta mode. Sampled only in IDLE.
- in_data, input, 32, operand word.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, the block accepts in_data this cycle.
- sub_dataa, output, 32, registered minuend to ahfp_sub.dataa.
- sub_datab, output, 32, registered subtrahend to ahfp_sub.datab.
- sub_result, input, 32, from ahfp_sub.result.
- out_data, output, 32, captured difference.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts.
- out_count, output, CNT_W, number of completed output handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sub_dataa=sub_datab=0, out_data=0, out_valid=0, out_count=0, lat counter=0, mode register=0.
- in_ready is combinational: 1 iff state is IDLE or SECOND and flush=0.
- An input word is accepted when in_valid & in_ready.
- A result is consumed when out_valid & out_ready.
- IDLE:
  - Latch delta_mode into the mode register every cycle.
  - On accept, pair mode: sub_dataa<=in_data. Delta mode: sub_datab<=in_data (this is the previous sample).
  - Then go to SECOND.
- SECOND:
  - On accept, pair mode: sub_datab<=in_data. Delta mode: sub_dataa<=in_data.
  - Load the lat counter with SUB_LAT-1 and go to EXEC.
- EXEC:
  - While the counter is nonzero, decrement it.
  - When the counter is 0: out_data<=sub_result, out_valid<=1, go to OUT.
  - With SUB_LAT=1, out_valid rises 2 clock edges after the second word is accepted. The operand registers are stable for the whole EXEC state.
- OUT:
  - out_valid and out_data are held stable until consumed. No input is accepted in OUT.
  - On consume: out_valid<=0 and out_count<=out_count+1.
  - Pair mode: go to IDLE.
  - Delta mode: sub_datab<=sub_dataa (the current sample becomes previous), then go to SECOND.
- Throughput: pair mode gives one result per 2+SUB_LAT+1 cycles at minimum, given no backpressure.
- flush=1 in any state, on the next edge: state=IDLE, out_valid=0, lat counter=0.
  - sub_dataa/sub_datab keep their values; out_count is unchanged.
  - A pending unconsumed result is dropped and not counted.
- flush together with in_valid: flush wins and the word is not accepted, because in_ready=0.
- flush together with a consume: flush wins and out_count does not increment.
- The mode change takes effect only in IDLE. A delta_mode toggle outside IDLE is ignored until the next IDLE.
- Stall: while out_ready=0 in OUT, all registers hold.
- out_count wraps from 2^CNT_W-1 to 0.
- No arithmetic is performed here. Special values (zero, inf, NaN, denormal) are passed through bit-exact from sub_result.
- Reset asserted mid-operation: everything returns immediately to reset values and partial pairs are lost.

Test Plan:
(Bench instantiates ahfp_sub between sub_dataa/sub_datab and sub_result, SUB_LAT=1.)
- Pair mode: send 3F800000, 40000000 with out_ready=1.
  - out_valid rises 2 cycles after the 2nd accept with out_data=BF800000.
  - out_count=1; state returns to IDLE with in_ready=1.
- Pair mode back-to-back: (40400000,40600000) then (43FA0000,41133333).
  - Outputs are BF000000 then 43F56666.
  - in_ready=0 during EXEC/OUT; out_count=2.
- Delta mode: stream 40000000, 40800000, 40400000.
  - Outputs are 40000000 (4-2), then BF800000 (3-4).
  - sub_datab tracks the previous sample; no output follows the first word.
- Backpressure: hold out_ready=0 for 5 cycles after the result of (42FF999A,42FCCCCD).
  - out_data stays 3FB33340 and out_valid stays 1; in_ready=0.
  - On release, exactly one handshake occurs.
- Flush: assert flush in EXEC, and separately in OUT with out_ready=0.
  - No output is produced and out_count is unchanged.
  - Next pair (3F800000,00000000) yields 3F800000.
  - flush with in_valid=1 accepts nothing.
- Async reset: pull reset_n low mid-EXEC between clock edges.
  - out_valid, out_data and out_count clear immediately without waiting for a clock edge.
  - After release, in_ready=1 on the first cycle.

Source files
------------

// File: rtl/ahfp_sub_feeder.sv
// Operand sequencer and result capture for the combinational ahfp_sub subtractor.
// Pairs stream words into held operand registers, waits SUB_LAT cycles, emits the difference.
//
// state  | meaning
// IDLE   | waiting for first word of a pair (pair mode) or first sample (delta mode)
// SECOND | waiting for the word that completes the operand pair
// EXEC   | operands stable, counting down subtractor latency
// OUT    | result held on out_data until downstream consumes it
module ahfp_sub_feeder #(
    parameter int SUB_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             delta_mode,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      sub_dataa,
    output logic [31:0]      sub_datab,
    input  logic [31:0]      sub_result,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {IDLE, SECOND, EXEC, OUT} state_t;

    localparam logic [3:0]       LAT_LOAD = 4'(SUB_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] lat_cnt;
    logic       mode_r;
    logic       accept;
    logic       consume;

    assign in_ready = ((state == IDLE) || (state == SECOND)) && !flush;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sub_dataa <= '0;
            sub_datab <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            lat_cnt   <= '0;
            mode_r    <= 1'b0;
        end else if (flush) begin
            // operand registers and the counter deliberately survive a flush
            state     <= IDLE;
            out_valid <= 1'b0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mode_r <= delta_mode;
                    if (accept) begin
                        if (delta_mode) sub_datab <= in_data;
                        else            sub_dataa <= in_data;
                        state <= SECOND;
                    end
                end
                SECOND: begin
                    if (accept) begin
                        if (mode_r) sub_dataa <= in_data;
                        else        sub_datab <= in_data;
                        lat_cnt <= LAT_LOAD;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        out_data  <= sub_result;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (consume) begin
                        out_valid <= 1'b0;
                        out_count <= out_count + CNT_ONE;
                        // in delta mode the current sample becomes the next subtrahend
                        if (mode_r) begin
                            sub_datab <= sub_dataa;
                            state     <= SECOND;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahfp_sub_feeder.sv
// Scoreboard bench for ahfp_sub_feeder with a behavioural stand-in for ahfp_sub.
// A pair/delta model predicts results; a negedge monitor checks the DUT against it.
module tb_ahfp_sub_feeder;

    localparam int SUB_LAT = 1;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             delta_mode = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      sub_dataa, sub_datab, sub_result, out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] out_count;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Known IEEE-754 differences; anything else gets a deterministic scramble.
    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'hBF800000;
            64'h40400000_40600000: return 32'hBF000000;
            64'h43FA0000_41133333: return 32'h43F56666;
            64'h40800000_40000000: return 32'h40000000;
            64'h40400000_40800000: return 32'hBF800000;
            64'h42FF999A_42FCCCCD: return 32'h3FB33340;
            64'h3F800000_00000000: return 32'h3F800000;
            64'h7F800000_7F800000: return 32'h7FC00000;
            64'h00000001_00000000: return 32'h00000001;
            default:               return (a ^ {b[7:0], b[31:8]}) + 32'd1;
        endcase
    endfunction

    assign sub_result = fsub(sub_dataa, sub_datab);

    ahfp_sub_feeder #(.SUB_LAT(SUB_LAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .delta_mode (delta_mode),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sub_dataa  (sub_dataa),
        .sub_datab  (sub_datab),
        .sub_result (sub_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] q[$];
    bit          busy, have_first, have_prev, mode_m, exp_valid;
    logic [31:0] first_w, prev_w, opa_m, opb_m;
    int          cyc = 0;
    int          acc_cyc = 0;
    int unsigned count_m = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            busy = 0; have_first = 0; have_prev = 0; mode_m = 0;
            count_m = 0;
        end else begin
            exp_valid = busy && ((cyc - acc_cyc) >= 1 + SUB_LAT);
            check("in_ready", 32'(in_ready), 32'(!flush && !busy));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("out_count", 32'(out_count), count_m % (1 << CNT_W));
            if (exp_valid && q.size() > 0) check("out_data", out_data, q[0]);
            if (busy) begin
                check("sub_dataa", sub_dataa, opa_m);
                check("sub_datab", sub_datab, opb_m);
            end else if (mode_m && have_prev) begin
                check("delta_prev", sub_datab, prev_w);
            end else if (!mode_m && have_first) begin
                check("pair_first", sub_dataa, first_w);
            end

            if (flush) begin
                q.delete();
                busy = 0; have_first = 0; have_prev = 0;
            end else begin
                if (!busy && !have_first && !have_prev) mode_m = delta_mode;
                if (out_valid && out_ready && exp_valid) begin
                    if (q.size() == 0) check("unexpected_output", out_data, 32'hFFFF_FFFF);
                    else void'(q.pop_front());
                    count_m++;
                    busy = 0;
                end
                if (in_valid && in_ready) begin
                    if (!mode_m) begin
                        if (!have_first) begin
                            first_w = in_data; have_first = 1;
                        end else begin
                            opa_m = first_w; opb_m = in_data;
                            q.push_back(fsub(first_w, in_data));
                            have_first = 0; busy = 1; acc_cyc = cyc;
                        end
                    end else begin
                        if (!have_prev) begin
                            prev_w = in_data; have_prev = 1;
                        end else begin
                            opa_m = in_data; opb_m = prev_w;
                            q.push_back(fsub(in_data, prev_w));
                            prev_w = in_data; busy = 1; acc_cyc = cyc;
                        end
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready) begin
            t++;
            if (t > 50) begin
                check("send_timeout", 32'(t), 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy || q.size() > 0) begin
            t++;
            if (t > 100) begin
                check("drain_timeout", 32'(q.size()), 32'd0);
                break;
            end
            cycles(1);
        end
        cycles(1);
    endtask

    initial begin
        cycles(2);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_sub_dataa", sub_dataa, 32'h0);
        check("rst_sub_datab", sub_datab, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        cycles(1);

        // pair mode
        send(32'h3F800000); send(32'h40000000);
        wait_idle();
        check("pair_count", 32'(out_count), 32'd1);

        // back-to-back pairs
        send(32'h40400000); send(32'h40600000);
        send(32'h43FA0000); send(32'h41133333);
        wait_idle();

        // delta mode, then flush back to IDLE and restore pair mode
        delta_mode = 1'b1;
        cycles(1);
        send(32'h40000000); send(32'h40800000); send(32'h40400000);
        wait_idle();
        flush = 1'b1; delta_mode = 1'b0;
        cycles(1);
        flush = 1'b0;
        cycles(1);

        // backpressure
        out_ready = 1'b0;
        send(32'h42FF999A); send(32'h42FCCCCD);
        cycles(6);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data", out_data, 32'h3FB33340);
        out_ready = 1'b1;
        wait_idle();

        // flush in EXEC
        send(32'h11111111); send(32'h22222222);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        cycles(2);
        // flush in OUT with a stalled consumer
        out_ready = 1'b0;
        send(32'h33333333); send(32'h44444444);
        cycles(1);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0; out_ready = 1'b1;
        cycles(2);
        // flush wins over in_valid
        in_valid = 1'b1; in_data = 32'h55555555; flush = 1'b1;
        cycles(2);
        flush = 1'b0; in_valid = 1'b0;
        cycles(1);
        send(32'h3F800000); send(32'h00000000);
        wait_idle();

        // special values pass through
        send(32'h7F800000); send(32'h7F800000);
        send(32'h00000001); send(32'h00000000);
        wait_idle();

        // randomized traffic with flushes, mode toggles and backpressure
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) delta_mode = ~delta_mode;
            cycles(1);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        cycles(8);
        flush = 1'b1; delta_mode = 1'b0;
        cycles(1);
        flush = 1'b0;
        cycles(1);

        // async reset mid-EXEC
        send(32'h3F800000); send(32'h40000000);
        send(32'h40400000); send(32'h40600000);
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", out_data, 32'h0);
        check("arst_out_count", 32'(out_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        cycles(1);
        send(32'h3F800000); send(32'h40000000);
        wait_idle();
        check("post_rst_count", 32'(out_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
